// File: rtl/branch_resolve_ctrl.sv
// Branch direction predictor (2-bit saturating BHT) with misprediction redirect
// and a timed front-end flush sequencer, plus saturating branch statistics.
module branch_resolve_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            recovering,
  output logic [15:0]     branch_count,
  output logic [15:0]     mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             res;
  logic             mis;
  logic             unused_if_pc;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign if_idx       = if_pc[IDX_W+1:2];
  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign unused_if_pc = ^if_pc;

  assign res = ex_valid & ex_is_branch & (state == RUN);
  assign mis = res & (ex_taken != ex_pred_taken);

  // Reads the registered table, so a same-cycle update is not yet visible.
  always_comb begin
    pred_taken = if_valid & bht[if_idx][1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= 4'd0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      flush_if_id   <= 1'b0;
      flush_id_ex   <= 1'b0;
      recovering    <= 1'b0;
      branch_count  <= 16'd0;
      mispred_count <= 16'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else begin
      redirect <= 1'b0;
      case (state)
        RUN: begin
          if (res) begin
            if (ex_taken) begin
              if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else begin
              if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
            if (branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
          end
          if (mis) begin
            if (mispred_count != 16'hFFFF) mispred_count <= mispred_count + 16'd1;
            state       <= RECOVER;
            cnt         <= 4'(FLUSH_CYCLES - 1);
            redirect    <= 1'b1;
            redirect_pc <= ex_taken ? ex_target : ex_pc + PC_W'(4);
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
            recovering  <= 1'b1;
          end
        end
        RECOVER: begin
          // EX inputs are ignored here; the counter alone times the flush window.
          if (cnt == 4'd0) begin
            state       <= RUN;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
            recovering  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (16 entries, 2-cycle flush).
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        recovering;
  logic [15:0] branch_count;
  logic [15:0] mispred_count;

  int assert_count = 0;
  int fail_count   = 0;

  branch_resolve_ctrl #(
    .BHT_ENTRIES (16),
    .FLUSH_CYCLES(2),
    .PC_W        (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_taken     (ex_taken),
    .ex_pred_taken(ex_pred_taken),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .recovering   (recovering),
    .branch_count (branch_count),
    .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic br, input logic tk,
                               input logic ptk, input logic [31:0] pc,
                               input logic [31:0] tgt);
    ex_valid      = v;
    ex_is_branch  = br;
    ex_taken      = tk;
    ex_pred_taken = ptk;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    if_valid = 1'b1;
    if_pc    = pc;
    #1;
    checkOutput(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0;
    if_pc = 32'h0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state and first lookup
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_flush_if_id", {31'd0, flush_if_id}, 32'd0);
    checkOutput("rst_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
    checkOutput("rst_recovering", {31'd0, recovering}, 32'd0);
    checkOutput("rst_branch_count", {16'd0, branch_count}, 32'd0);
    checkOutput("rst_mispred_count", {16'd0, mispred_count}, 32'd0);
    lookup("rst_pred_0x100", 32'h100, 1'b0);
    if_valid = 1'b0;
    #1;
    checkOutput("pred_if_valid_low", {31'd0, pred_taken}, 32'd0);

    // Training: first resolve mispredicts (01 -> 10), read still sees old value
    lookup("pred_before_train", 32'h100, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h300);
    #1;
    checkOutput("read_during_write", {31'd0, pred_taken}, 32'd0);
    tick();
    idle();
    checkOutput("train1_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("train1_redirect_pc", redirect_pc, 32'h300);
    checkOutput("train1_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("train1_branch_count", {16'd0, branch_count}, 32'd1);
    checkOutput("train1_mispred_count", {16'd0, mispred_count}, 32'd1);
    tick();
    checkOutput("train1_redirect_once", {31'd0, redirect}, 32'd0);
    checkOutput("train1_recovering_c2", {31'd0, recovering}, 32'd1);
    tick();
    checkOutput("train1_recover_done", {31'd0, recovering}, 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h300);
    tick();
    idle();
    checkOutput("train2_no_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("train2_branch_count", {16'd0, branch_count}, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h300);
    tick();
    idle();
    checkOutput("train3_branch_count", {16'd0, branch_count}, 32'd3);
    checkOutput("train3_mispred_count", {16'd0, mispred_count}, 32'd1);
    lookup("alias_pred_0x140", 32'h140, 1'b1);

    // Counter must be saturated at 11: one not-taken leaves it at 10 (still taken)
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h300);
    tick();
    idle();
    checkOutput("sat_nt_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("sat_nt_redirect_pc", redirect_pc, 32'h104);
    checkOutput("sat_nt_mispred_count", {16'd0, mispred_count}, 32'd2);
    tick();
    tick();
    lookup("sat_pred_0x100", 32'h100, 1'b1);

    // Taken mispredict with a second mispredict presented during RECOVER
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lookup("pred_0x200_fresh", 32'h200, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h80);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h204, 32'h999);
    checkOutput("tk_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("tk_redirect_pc", redirect_pc, 32'h80);
    checkOutput("tk_flush_if_id_c1", {31'd0, flush_if_id}, 32'd1);
    checkOutput("tk_flush_id_ex_c1", {31'd0, flush_id_ex}, 32'd1);
    checkOutput("tk_recovering_c1", {31'd0, recovering}, 32'd1);
    tick();
    checkOutput("tk_redirect_c2", {31'd0, redirect}, 32'd0);
    checkOutput("tk_flush_if_id_c2", {31'd0, flush_if_id}, 32'd1);
    checkOutput("tk_flush_id_ex_c2", {31'd0, flush_id_ex}, 32'd1);
    checkOutput("tk_redirect_pc_c2", redirect_pc, 32'h80);
    tick();
    idle();
    checkOutput("tk_redirect_c3", {31'd0, redirect}, 32'd0);
    checkOutput("tk_flush_if_id_c3", {31'd0, flush_if_id}, 32'd0);
    checkOutput("tk_flush_id_ex_c3", {31'd0, flush_id_ex}, 32'd0);
    checkOutput("tk_recovering_c3", {31'd0, recovering}, 32'd0);
    checkOutput("tk_redirect_pc_hold", redirect_pc, 32'h80);
    checkOutput("ignored_branch_count", {16'd0, branch_count}, 32'd1);
    checkOutput("ignored_mispred_count", {16'd0, mispred_count}, 32'd1);
    lookup("ignored_bht_0x204", 32'h204, 1'b0);
    lookup("trained_bht_0x200", 32'h200, 1'b1);

    // Not-taken mispredict with PC wrap, then reset in the first RECOVER cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    tick();
    idle();
    checkOutput("wrap_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("wrap_redirect_pc", redirect_pc, 32'h0);
    checkOutput("wrap_mispred_count", {16'd0, mispred_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("midrst_flush_if_id", {31'd0, flush_if_id}, 32'd0);
    checkOutput("midrst_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
    checkOutput("midrst_recovering", {31'd0, recovering}, 32'd0);
    checkOutput("midrst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("midrst_branch_count", {16'd0, branch_count}, 32'd0);
    checkOutput("midrst_mispred_count", {16'd0, mispred_count}, 32'd0);
    lookup("midrst_pred_0x200", 32'h200, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
    tick();
    idle();
    checkOutput("midrst_run_branch_count", {16'd0, branch_count}, 32'd1);
    checkOutput("midrst_run_no_redirect", {31'd0, redirect}, 32'd0);

    // Mispredict coinciding with reset is discarded
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checkOutput("rstmis_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rstmis_recovering", {31'd0, recovering}, 32'd0);
    checkOutput("rstmis_mispred_count", {16'd0, mispred_count}, 32'd0);
    checkOutput("rstmis_branch_count", {16'd0, branch_count}, 32'd0);
    lookup("rstmis_pred_0x300", 32'h300, 1'b0);

    // Statistics saturation: 65537 correctly predicted resolves
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h308, 32'h0);
    repeat (65534) tick();
    checkOutput("sat_branch_fffe", {16'd0, branch_count}, 32'h0000_FFFE);
    repeat (3) tick();
    idle();
    checkOutput("sat_branch_ffff", {16'd0, branch_count}, 32'h0000_FFFF);
    checkOutput("sat_mispred_zero", {16'd0, mispred_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Branch-direction predictor and misprediction recovery sequencer for the pipelined core.
- Fetch side: a PC-indexed table of 2-bit saturating counters supplies the predicted direction.
- Execute side: consumes the resolved branch outcome from the branch-condition logic, trains the table, and on a misprediction issues a PC redirect plus a timed flush of the front-end pipeline registers.
- Also keeps branch and misprediction statistics counters.

Parameters:
BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2.
IDX_W, $clog2(BHT_ENTRIES), index width; derived, do not override.
FLUSH_CYCLES, 2, recovery length in cycles; ≥1, ≤15.
PC_W, 32, program-counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch-stage lookup valid
if_pc  in  PC_W  fetch PC
pred_taken  out  1  predicted direction for if_pc
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_taken  in  1  resolved direction from branch-condition logic
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pc  in  PC_W  PC of EX instruction
ex_target  in  PC_W  computed branch target
redirect  out  1  one-cycle PC-override pulse
redirect_pc  out  PC_W  correct next PC; valid when redirect=1
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
recovering  out  1  high while in RECOVER
branch_count  out  16  resolved branches, saturating
mispred_count  out  16  mispredictions, saturating

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: rst has priority over every other event, including mid-RECOVER.
  - State returns to RUN.
  - All BHT counters set to 2'b01 (weakly not-taken).
  - redirect, flush_if_id, flush_id_ex and recovering = 0; redirect_pc = 0; both statistics counters = 0.
- Index: idx = pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Lookup:
  - pred_taken = if_valid & BHT[idx(if_pc)][1]. Combinational, zero latency.
  - Read-during-write to the same entry returns the pre-update value.
- Resolve event: res = ex_valid & ex_is_branch & (state==RUN). Non-branch ex_valid is ignored.
- Training on res, registered at the clock edge:
  - If ex_taken, BHT[idx(ex_pc)] increments, saturating at 2'b11.
  - Otherwise it decrements, saturating at 2'b00.
- Statistics:
  - On res, branch_count increments, saturating at 16'hFFFF.
  - On mispredict, mispred_count increments, saturating at 16'hFFFF.
- Mispredict: mis = res & (ex_taken != ex_pred_taken).
- FSM has two states, RUN and RECOVER, plus a down-counter cnt (4 bits).
- RUN:
  - If mis, at the edge: state → RECOVER, cnt ← FLUSH_CYCLES-1, redirect ← 1, redirect_pc ← ex_taken ? ex_target : ex_pc+4 (PC_W-bit wrap), flush_if_id ← 1, flush_id_ex ← 1, recovering ← 1.
  - Outputs are therefore visible in the cycle after detection (latency 1).
- RECOVER:
  - redirect is high only in the first RECOVER cycle; it is 0 in later cycles.
  - Flush outputs and recovering stay high for exactly FLUSH_CYCLES cycles.
  - All ex_* inputs are ignored: no training, no counting, no new mispredict.
  - When cnt==0 at the edge: state → RUN and all flush/recovering outputs → 0. Otherwise cnt decrements.
  - redirect_pc holds its value until the next mispredict.
- Lookups (if_valid/pred_taken) continue normally during RECOVER.
- A mispredict in the last RUN cycle before a reset is discarded by the reset.

Test Plan:
- Reset then lookup: rst 1 cycle; if_valid=1, if_pc=0x100 → pred_taken=0; recovering=0; branch_count=0.
- Training saturation: three resolves at ex_pc=0x100 with ex_taken=1 and ex_pred_taken matching the current prediction → counter 01→10→11→11; after the first, pred_taken for 0x100 = 1; 0x140 (same idx at 16 entries) also returns 1; mispred_count = 1 (first resolve mispredicted).
- Taken mispredict: counter at 01; ex_pc=0x200, ex_target=0x80, ex_taken=1, ex_pred_taken=0 → next cycle redirect=1, redirect_pc=0x80, flush_if_id=flush_id_ex=1 for exactly 2 cycles; redirect high 1 cycle only.
- Not-taken mispredict with wrap: ex_pc=0xFFFFFFFC, ex_taken=0, ex_pred_taken=1 → redirect_pc=0x00000000.
- Inputs ignored in RECOVER: a second mispredicting branch presented during both RECOVER cycles → no second redirect; branch_count and mispred_count unchanged; BHT entry unchanged.
- Reset mid-RECOVER: assert rst in the first RECOVER cycle → next cycle all outputs 0, state RUN, every entry predicts not-taken.
- Counter saturation: 65,537 resolves → branch_count = 16'hFFFF.
